// File: rtl/traffic_pkg.sv
// traffic_pkg: state encoding and widths shared by the pedestrian request path
package traffic_pkg;
    localparam int REQ_CNT_W = 8;
    typedef enum logic [1:0] {
        PRQ_IDLE    = 2'd0,
        PRQ_ARMED   = 2'd1,
        PRQ_SERVING = 2'd2
    } prq_state_e;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop sync, counter debounce and one-cycle rising-edge pulse
//   raw in (async, bouncy) -> deb (debounced level), press (one cycle after deb rises)
module btn_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb,
    output logic press
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
    logic s1_q, s1_d, s2_q, s2_d, deb_q, deb_d, prev_q, prev_d, press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        s1_d = raw;
        s2_d = s1_q;
        deb_d = (s2_q != deb_q && cnt_q == LAST) ? s2_q : deb_q;
        cnt_d = (s2_q != deb_q && cnt_q != LAST) ? cnt_q + 1'b1 : '0;
        prev_d = deb_q;
        press_d = deb_q & ~prev_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            deb_q <= 1'b0;
            prev_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            deb_q <= deb_d;
            prev_q <= prev_d;
            press_q <= press_d;
            cnt_q <= cnt_d;
        end
    end
    assign deb = deb_q;
    assign press = press_q;
endmodule

// File: rtl/ped_request_unit.sv
// ped_request_unit: latches one debounced crossing request and holds btn until granted
//   in: btn_raw, ped_green, ped_red; out: btn, wait_led, served, req_timeout, req_cnt
module ped_request_unit
    import traffic_pkg::*;
#(
    parameter int DB_CYCLES = 4,
    parameter int BLINK_DIV = 1,
    parameter int TIMEOUT = 120
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_raw,
    input  logic                 ped_green,
    input  logic                 ped_red,
    output logic                 btn,
    output logic                 wait_led,
    output logic                 served,
    output logic                 req_timeout,
    output logic [REQ_CNT_W-1:0] req_cnt
);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] BLAST = BW'(BLINK_DIV - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT);
    prq_state_e state_q, state_d;
    logic deb, press, arm, stay;
    logic btn_q, btn_d, wait_q, wait_d, served_q, served_d, tmo_q, tmo_d;
    logic [BW-1:0] blink_q, blink_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [REQ_CNT_W-1:0] cnt_q, cnt_d;
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_raw),
        .deb  (deb),
        .press(press)
    );
    always_comb begin
        state_d = state_q;
        case (state_q)
            PRQ_IDLE:    state_d = (press && deb && ped_red && !ped_green) ? PRQ_ARMED : PRQ_IDLE;
            PRQ_ARMED:   state_d = ped_green ? PRQ_SERVING : PRQ_ARMED;
            PRQ_SERVING: state_d = ped_green ? PRQ_SERVING : PRQ_IDLE;
            default:     state_d = PRQ_IDLE;
        endcase
        arm = state_q == PRQ_IDLE && state_d == PRQ_ARMED;
        stay = state_q == PRQ_ARMED && state_d == PRQ_ARMED;
        btn_d = state_d == PRQ_ARMED;
        served_d = state_q == PRQ_ARMED && state_d == PRQ_SERVING;
        blink_d = (stay && blink_q != BLAST) ? blink_q + 1'b1 : '0;
        wait_d = arm ? 1'b1 : stay ? (blink_q == BLAST ? ~wait_q : wait_q) : 1'b0;
        // saturates at TIMEOUT; a grant leaves ARMED so tcnt_d is 0 and cannot set the flag
        tcnt_d = stay ? (tcnt_q == TLAST ? tcnt_q : tcnt_q + 1'b1) : '0;
        tmo_d = tmo_q | (tcnt_d == TLAST);
        cnt_d = (arm && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PRQ_IDLE;
            btn_q <= 1'b0;
            wait_q <= 1'b0;
            served_q <= 1'b0;
            tmo_q <= 1'b0;
            blink_q <= '0;
            tcnt_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            btn_q <= btn_d;
            wait_q <= wait_d;
            served_q <= served_d;
            tmo_q <= tmo_d;
            blink_q <= blink_d;
            tcnt_q <= tcnt_d;
            cnt_q <= cnt_d;
        end
    end
    assign btn = btn_q;
    assign wait_led = wait_q;
    assign served = served_q;
    assign req_timeout = tmo_q;
    assign req_cnt = cnt_q;
endmodule

// File: tb/tb_ped_request_unit.sv
// tb_ped_request_unit: directed and random stimulus checked against a behavioural model
module tb_ped_request_unit;
    localparam int DB = 4;
    localparam int BD = 1;
    localparam int TO = 10;
    logic clk = 1'b0, rst = 1'b1, btn_raw = 1'b0, ped_green = 1'b0, ped_red = 1'b1;
    logic btn, wait_led, served, req_timeout;
    logic [7:0] req_cnt;
    int checks = 0, errors = 0;
    bit m_s1, m_s2, m_deb, m_prev, m_press, m_served, m_tmo;
    int m_run, m_mode, m_age, m_cnt;
    ped_request_unit #(.DB_CYCLES(DB), .BLINK_DIV(BD), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .ped_green  (ped_green),
        .ped_red    (ped_red),
        .btn        (btn),
        .wait_led   (wait_led),
        .served     (served),
        .req_timeout(req_timeout),
        .req_cnt    (req_cnt)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    // m_mode: 0 no request, 1 request pending, 2 crossing in progress
    task automatic model_step();
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_deb = 0; m_prev = 0; m_press = 0; m_served = 0; m_tmo = 0;
            m_run = 0; m_mode = 0; m_age = 0; m_cnt = 0;
            return;
        end
        m_served = 0;
        if (m_mode == 1) begin
            if (ped_green) begin
                m_mode = 2;
                m_served = 1;
            end else begin
                m_age++;
                if (m_age >= TO) m_tmo = 1;
            end
        end else if (m_mode == 2) begin
            if (!ped_green) m_mode = 0;
        end else if (m_press && ped_red && !ped_green) begin
            m_mode = 1;
            m_age = 0;
            if (m_cnt < 255) m_cnt++;
        end
        m_press = m_deb && !m_prev;
        m_prev = m_deb;
        if (m_s2 != m_deb) begin
            m_run++;
            if (m_run == DB) begin
                m_deb = m_s2;
                m_run = 0;
            end
        end else m_run = 0;
        m_s2 = m_s1;
        m_s1 = btn_raw;
    endtask
    task automatic compare();
        check("btn", btn, m_mode == 1);
        check("wait_led", wait_led, m_mode == 1 && ((m_age / BD) % 2 == 0));
        check("served", served, m_served);
        check("req_timeout", req_timeout, m_tmo);
        check("req_cnt", req_cnt, m_cnt);
    endtask
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            compare();
        end
    endtask
    task automatic wait_btn(input string tag);
        int n = 0;
        while (btn !== 1'b1 && n < 30) begin
            cyc();
            n++;
        end
        check(tag, btn, 1);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        btn_raw = 1'b0;
        ped_green = 1'b0;
        ped_red = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(8);
    endtask
    initial begin
        int n, rlen, glen;
        cyc(3);
        check("reset_btn", btn, 0);
        check("reset_cnt", req_cnt, 0);
        rst = 1'b0;
        cyc(2);
        for (int r = 0; r < 2; r++)
            for (int p = 1; p <= 3; p++) begin
                btn_raw = 1'b1;
                cyc(p);
                btn_raw = 1'b0;
                cyc(1);
            end
        cyc(8);
        check("bounce_btn", btn, 0);
        check("bounce_cnt", req_cnt, 0);
        btn_raw = 1'b1;
        n = 0;
        while (btn !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        check("latency", n - 1, DB + 3);
        check("entry_wait", wait_led, 1);
        check("cnt_one", req_cnt, 1);
        cyc();
        check("blink_a", wait_led, 0);
        cyc();
        check("blink_b", wait_led, 1);
        btn_raw = 1'b0;
        cyc(3);
        ped_green = 1'b1;
        ped_red = 1'b0;
        cyc();
        check("grant_btn", btn, 0);
        check("grant_served", served, 1);
        cyc();
        check("served_once", served, 0);
        ped_green = 1'b0;
        ped_red = 1'b1;
        cyc(3);
        do_reset();
        btn_raw = 1'b1;
        wait_btn("hold_arm");
        ped_green = 1'b1;
        ped_red = 1'b0;
        cyc(3);
        ped_green = 1'b0;
        ped_red = 1'b1;
        cyc(15);
        check("no_rearm", btn, 0);
        btn_raw = 1'b0;
        cyc(10);
        btn_raw = 1'b1;
        wait_btn("rearm");
        check("cnt_two", req_cnt, 2);
        btn_raw = 1'b0;
        do_reset();
        btn_raw = 1'b1;
        wait_btn("tmo_arm");
        btn_raw = 1'b0;
        cyc(TO - 1);
        check("tmo_early", req_timeout, 0);
        cyc();
        check("tmo_set", req_timeout, 1);
        check("tmo_btn", btn, 1);
        cyc(5);
        ped_green = 1'b1;
        ped_red = 1'b0;
        cyc();
        check("tmo_grant_btn", btn, 0);
        ped_green = 1'b0;
        ped_red = 1'b1;
        cyc(5);
        check("tmo_sticky", req_timeout, 1);
        do_reset();
        check("tmo_cleared", req_timeout, 0);
        btn_raw = 1'b1;
        wait_btn("race_arm");
        btn_raw = 1'b0;
        cyc(TO - 1);
        ped_green = 1'b1;
        ped_red = 1'b0;
        cyc();
        check("race_tmo", req_timeout, 0);
        check("race_served", served, 1);
        cyc(8);
        btn_raw = 1'b1;
        cyc(12);
        ped_green = 1'b0;
        ped_red = 1'b1;
        cyc(4);
        check("green_press_drop", btn, 0);
        btn_raw = 1'b0;
        do_reset();
        btn_raw = 1'b1;
        wait_btn("rst_arm");
        btn_raw = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc();
        check("rst_btn", btn, 0);
        check("rst_wait", wait_led, 0);
        check("rst_cnt", req_cnt, 0);
        rst = 1'b0;
        rlen = 1;
        glen = 1;
        for (int i = 0; i < 1500; i++) begin
            if (rlen == 0) begin
                btn_raw = ~btn_raw;
                rlen = $urandom_range(1, 12);
            end
            rlen--;
            if (glen == 0) begin
                ped_green = ~ped_green;
                glen = $urandom_range(1, 25);
            end
            glen--;
            ped_red = !ped_green && ($urandom_range(0, 7) != 0);
            rst = $urandom_range(0, 399) == 0;
            cyc();
        end
        do_reset();
        for (int k = 0; k < 260; k++) begin
            btn_raw = 1'b1;
            cyc(10);
            btn_raw = 1'b0;
            ped_green = 1'b1;
            ped_red = 1'b0;
            cyc(2);
            ped_green = 1'b0;
            ped_red = 1'b1;
            cyc(6);
        end
        check("saturate", req_cnt, 255);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ped_request_unit.md
# ped_request_unit

Pedestrian-side front end for the button-actioned crossing controller. It synchronises and debounces the raw push-button and latches one crossing request. It presents that request as the level `btn` to the traffic-light controller and holds it until the controller grants the crossing (`ped_green`). It also drives the "WAIT" indicator and keeps request/timeout bookkeeping. It sits between the board pin and the controller's `btn` input, and reads back the controller's `ped_green`/`ped_red` outputs.

## Interface
- `DB_CYCLES`, 4: consecutive stable synchronised samples required to change the debounced button state (≥2).
- `BLINK_DIV`, 1: `wait_led` toggles every `BLINK_DIV` cycles while a request is pending (≥1).
- `TIMEOUT`, 120: cycles in ARMED without a grant before `req_timeout` is set (≥1).
- `clk` input 1: single system clock; all flops rise-edge.
- `rst` input 1: synchronous, active-high reset.
- `btn_raw` input 1: raw push-button, asynchronous and bouncy, active-high.
- `ped_green` input 1: controller's pedestrian green.
- `ped_red` input 1: controller's pedestrian red.
- `btn` output 1: registered request level to the controller.
- `wait_led` output 1: registered WAIT indicator.
- `served` output 1: one-cycle pulse when the pending request is granted.
- `req_timeout` output 1: sticky flag, cleared only by `rst`.
- `req_cnt` output 8: accepted-request count, saturating at 255.

## Operation
- Sync: two-flop synchroniser `btn_raw` → `s2`.
- Debounce: register `deb` plus a counter of width clog2(DB_CYCLES).
  - Counter increments while `s2 != deb` and clears when `s2 == deb`.
  - When `s2 != deb` and the counter equals `DB_CYCLES-1`, `deb <= s2` and the counter clears.
  - `press` = `deb` rose on this edge (registered edge detect, one cycle).
- FSM states are IDLE, ARMED, SERVING.
  - IDLE: `press && ped_red && !ped_green` → ARMED, and `req_cnt` increments (saturating). A press while `ped_green` is high is discarded.
  - ARMED: `ped_green` → SERVING, with `served` pulsing for that single cycle. Otherwise the FSM stays in ARMED. Further presses are ignored and do not count.
  - SERVING: `!ped_green` → IDLE. Presses are ignored.
- A held button never re-arms, because arming needs a fresh `deb` rising edge.
- `btn` is 1 exactly while the state is ARMED.
- `wait_led` in ARMED:
  - Starts at 1 on entry.
  - Toggles each time a blink counter reaches `BLINK_DIV-1`; the counter then wraps to 0.
- `wait_led` is 0 in IDLE and SERVING. The blink counter clears outside ARMED.
- Timeout counter:
  - Counts cycles spent in ARMED and clears on leaving ARMED.
  - Reaching `TIMEOUT` sets `req_timeout`.
  - The counter saturates there; the FSM stays in ARMED and keeps requesting.
- Illegal or unused state encoding → IDLE on the next edge.

## Timing
- Reset (sync, highest priority):
  - State goes to IDLE.
  - `btn`, `wait_led`, `served`, `req_timeout` all go to 0, and `req_cnt` goes to 0.
  - Sync flops, `deb`, and all counters go to 0.
- Reset asserted mid-request drops `btn` on the same edge. The button must be released and re-pressed after reset to arm again.
- Press latency, with edge E0 being the first edge sampling `btn_raw` = 1 and a clean input:
  - `s2` = 1 after E1.
  - `deb` = 1 after E(DB_CYCLES+1).
  - `press` is high after E(DB_CYCLES+2).
  - `btn` = 1 after E(DB_CYCLES+3).
  - With `DB_CYCLES`=4, `btn` rises 7 edges after the button.
- Grant latency: `ped_green` sampled high at edge E → after E, `btn` = 0 and `served` = 1. After E+1, `served` = 0.
- Bounce shorter than `DB_CYCLES` cycles is rejected entirely.
- Release is debounced symmetrically and has no effect on the FSM.
- Simultaneous events:
  - `press` and `ped_green` in IDLE on the same cycle: the press is discarded.
  - `ped_green` and the timeout reached on the same ARMED cycle: the grant wins and `req_timeout` is not set.
- `req_cnt` at 255 stays at 255.

## Structure
- Shared package `traffic_pkg` holds the FSM state encoding localparams (`PRQ_IDLE`, `PRQ_ARMED`, `PRQ_SERVING`) and `REQ_CNT_W` = 8.
- One sub-module, `btn_debounce`, covers the synchroniser, the debounce counter and the rising-edge pulse. Its ports are `clk`, `rst`, `raw`, `deb`, `press`, and it has parameter `DB_CYCLES`.
- The top level holds the FSM, the blink and timeout counters, and `req_cnt`.

## Test plan
- Clean press, with `ped_red`=1 and `DB_CYCLES`=4:
  - `btn` rises exactly 7 edges after `btn_raw`.
  - `wait_led` = 1 on entry, then toggles each cycle with `BLINK_DIV`=1.
  - `req_cnt` = 1.
- Bounce: `btn_raw` pulses of 1–3 cycles separated by 1-cycle lows → `btn` stays 0 and `req_cnt` stays 0.
- Grant: raise `ped_green` while in ARMED → on the next edge `btn`=0 and `served`=1 for one cycle. Drop `ped_green` → IDLE.
- Button held through the whole crossing → no re-arm after `ped_green` falls. Release then press → second request, `req_cnt`=2.
- Timeout, with `TIMEOUT`=10 and `ped_green` held low:
  - `req_timeout` = 1 after 10 ARMED cycles, with `btn` still 1.
  - Grant then clears `btn`; `req_timeout` stays 1 until `rst`.
- Reset and saturation:
  - `rst` mid-ARMED → all outputs 0 on the same edge.
  - 260 accepted requests → `req_cnt`=255.
